// File: rtl/gb_sdram_pkg.sv
// Shared types and constants for the GameBoy SDRAM arbiter.
// Exports FSM/owner enums, SDRAM address width and the cart-RAM base address.
package gb_sdram_pkg;

   localparam int SDRAM_AW = 26;

   localparam logic [SDRAM_AW-1:0] SDRAM_RAM_BASE = 26'h2000000;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      DONE
   } arb_state_t;

   typedef enum logic {
      OWN_GB,
      OWN_HPS
   } arb_owner_t;

endpackage

// File: rtl/gb_bus_watchdog.sv
// Counts stalled bus cycles and flags the cycle in which a phase must abort.
// Ports: clk, reset (async low), start (clear), stall (count), expire.
module gb_bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic stall,
   output logic expire
);

   localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WW-1:0] LAST = WW'(TIMEOUT_CYCLES - 1);

   logic [WW-1:0] wd_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
      end else if (start) begin
         wd_cnt <= '0;
      end else if (stall) begin
         wd_cnt <= wd_cnt + WW'(1);
      end
   end

   // The stalled cycle that sees LAST is the final one allowed.
   assign expire = stall && (wd_cnt == LAST);

endmodule

// File: rtl/gb_sdram_arbiter.sv
// Shares one 8-bit Avalon-MM SDRAM master between the GB cart path and HPS.
// Ports: clk, reset, gb_* / hps_* request ports, Avalon master, timeout_err.
module gb_sdram_arbiter
   import gb_sdram_pkg::*;
#(
   parameter int GB_STARVE_MAX  = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                gb_enable,
   input  logic                gb_req,
   input  logic                gb_we,
   input  logic [SDRAM_AW-1:0] gb_addr,
   input  logic [7:0]          gb_wdata,
   output logic                gb_ack,
   output logic [7:0]          gb_rdata,
   input  logic                hps_req,
   input  logic                hps_we,
   input  logic [SDRAM_AW-1:0] hps_addr,
   input  logic [7:0]          hps_wdata,
   output logic                hps_ack,
   output logic [7:0]          hps_rdata,
   output logic [SDRAM_AW-1:0] address,
   output logic                read,
   output logic                write,
   output logic [7:0]          writedata,
   input  logic [7:0]          readdata,
   input  logic                waitrequest,
   output logic                timeout_err
);

   localparam int SW =
      (GB_STARVE_MAX > 0) ? $clog2(GB_STARVE_MAX + 1) : 1;
   localparam logic [SW-1:0] STARVE_TOP = SW'(GB_STARVE_MAX);

   arb_state_t    state;
   arb_owner_t    owner;
   logic [SW-1:0] starve_cnt;

   logic gb_win;
   logic hps_win;
   logic wd_start;
   logic wd_stall;
   logic wd_expire;
   logic [7:0] cap_data;

   // HPS overrides GB priority only once GB has used its streak.
   assign gb_win  = gb_req && gb_enable &&
                    !(hps_req && (starve_cnt == STARVE_TOP));
   assign hps_win = hps_req && !gb_win;

   assign wd_start = (state == IDLE) && (gb_win || hps_win);
   assign wd_stall = (state == BUS) && waitrequest;

   // An aborted read returns all-ones, like an undriven bus.
   assign cap_data = waitrequest ? 8'hFF : readdata;

   gb_bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wd (
      .clk    (clk),
      .reset  (reset),
      .start  (wd_start),
      .stall  (wd_stall),
      .expire (wd_expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= OWN_GB;
         starve_cnt  <= '0;
         address     <= '0;
         writedata   <= '0;
         read        <= 1'b0;
         write       <= 1'b0;
         gb_ack      <= 1'b0;
         hps_ack     <= 1'b0;
         gb_rdata    <= 8'hFF;
         hps_rdata   <= 8'hFF;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!hps_req) begin
                  starve_cnt <= '0;
               end
               if (gb_win) begin
                  owner     <= OWN_GB;
                  address   <= gb_addr;
                  writedata <= gb_wdata;
                  read      <= !gb_we;
                  write     <= gb_we;
                  state     <= BUS;
                  if (hps_req && (starve_cnt != STARVE_TOP)) begin
                     starve_cnt <= starve_cnt + SW'(1);
                  end
               end else if (hps_win) begin
                  owner      <= OWN_HPS;
                  address    <= hps_addr;
                  writedata  <= hps_wdata;
                  read       <= !hps_we;
                  write      <= hps_we;
                  state      <= BUS;
                  starve_cnt <= '0;
               end
            end
            BUS: begin
               if (!waitrequest || wd_expire) begin
                  read  <= 1'b0;
                  write <= 1'b0;
                  state <= DONE;
                  if (waitrequest) begin
                     timeout_err <= 1'b1;
                  end
                  if (owner == OWN_GB) begin
                     gb_ack <= 1'b1;
                     if (read) begin
                        gb_rdata <= cap_data;
                     end
                  end else begin
                     hps_ack <= 1'b1;
                     if (read) begin
                        hps_rdata <= cap_data;
                     end
                  end
               end
            end
            DONE: begin
               gb_ack  <= 1'b0;
               hps_ack <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gb_sdram_arbiter.sv
// Self-checking bench for gb_sdram_arbiter: directed cases plus random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_gb_sdram_arbiter;

   localparam int STARVE = 4;
   localparam int TO     = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        gb_enable, gb_req, gb_we;
   logic [25:0] gb_addr;
   logic [7:0]  gb_wdata, gb_rdata;
   logic        gb_ack;
   logic        hps_req, hps_we;
   logic [25:0] hps_addr;
   logic [7:0]  hps_wdata, hps_rdata;
   logic        hps_ack;
   logic [25:0] address;
   logic        read, write, waitrequest, timeout_err;
   logic [7:0]  writedata, readdata;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   gb_sdram_arbiter #(
      .GB_STARVE_MAX  (STARVE),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .gb_enable   (gb_enable),
      .gb_req      (gb_req),
      .gb_we       (gb_we),
      .gb_addr     (gb_addr),
      .gb_wdata    (gb_wdata),
      .gb_ack      (gb_ack),
      .gb_rdata    (gb_rdata),
      .hps_req     (hps_req),
      .hps_we      (hps_we),
      .hps_addr    (hps_addr),
      .hps_wdata   (hps_wdata),
      .hps_ack     (hps_ack),
      .hps_rdata   (hps_rdata),
      .address     (address),
      .read        (read),
      .write       (write),
      .writedata   (writedata),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                    name, act, exp, $time);
   endtask

   // Model: expected outputs are its state. A command on the bus means a
   // transfer is in flight; an ack means the completion cycle.
   logic        e_read, e_write, e_gb_ack, e_hps_ack, e_terr;
   logic [25:0] e_addr;
   logic [7:0]  e_wdata, e_gb_rdata, e_hps_rdata;
   bit          m_hps;
   int          stall_run;
   int          streak;

   task automatic model_reset();
      e_read = 0; e_write = 0; e_gb_ack = 0; e_hps_ack = 0; e_terr = 0;
      e_addr = '0; e_wdata = '0;
      e_gb_rdata = 8'hFF; e_hps_rdata = 8'hFF;
      m_hps = 0; stall_run = 0; streak = 0;
   endtask

   task automatic grant(input bit hps);
      m_hps     = hps;
      e_addr    = hps ? hps_addr : gb_addr;
      e_wdata   = hps ? hps_wdata : gb_wdata;
      e_write   = hps ? hps_we : gb_we;
      e_read    = !e_write;
      stall_run = 0;
   endtask

   task automatic model_step();
      bit gb_ok, hps_first, to;
      logic [7:0] v;
      if (e_gb_ack || e_hps_ack) begin
         e_gb_ack = 0;
         e_hps_ack = 0;
      end else if (e_read || e_write) begin
         if (!waitrequest || stall_run == TO - 1) begin
            to = waitrequest;
            v = to ? 8'hFF : readdata;
            if (e_read) begin
               if (m_hps) e_hps_rdata = v;
               else e_gb_rdata = v;
            end
            if (m_hps) e_hps_ack = 1;
            else e_gb_ack = 1;
            if (to) e_terr = 1;
            e_read = 0;
            e_write = 0;
         end else begin
            stall_run++;
         end
      end else begin
         gb_ok = gb_req && gb_enable;
         hps_first = hps_req && (streak == STARVE);
         if (gb_ok && !hps_first) begin
            grant(0);
            if (!hps_req) streak = 0;
            else if (streak < STARVE) streak++;
         end else if (hps_req) begin
            grant(1);
            streak = 0;
         end else begin
            streak = 0;
         end
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("read", 32'(read), 32'(e_read));
         chk("write", 32'(write), 32'(e_write));
         chk("address", 32'(address), 32'(e_addr));
         chk("writedata", 32'(writedata), 32'(e_wdata));
         chk("gb_ack", 32'(gb_ack), 32'(e_gb_ack));
         chk("hps_ack", 32'(hps_ack), 32'(e_hps_ack));
         chk("gb_rdata", 32'(gb_rdata), 32'(e_gb_rdata));
         chk("hps_rdata", 32'(hps_rdata), 32'(e_hps_rdata));
         chk("timeout_err", 32'(timeout_err), 32'(e_terr));
      end
   end

   // Collect up to n acks within budget cycles; newest ack in bit 0,
   // 1 = HPS. Optionally flips gb_enable at the ack numbered flip_at.
   task automatic collect(input int n, input int budget, input int flip_at,
                          input logic flip_val,
                          output logic [15:0] seq, output int got);
      seq = '0;
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge clk);
         if (gb_ack || hps_ack) begin
            seq = {seq[14:0], hps_ack};
            got++;
            if (got == flip_at) gb_enable = flip_val;
         end
      end
   endtask

   task automatic drive_random(inout bit stuck);
      if (gb_ack || !gb_req) begin
         gb_req   = ($urandom_range(0, 2) != 0);
         gb_we    = 1'($urandom_range(0, 1));
         gb_addr  = 26'($urandom);
         gb_wdata = 8'($urandom);
      end
      if (hps_ack || !hps_req) begin
         hps_req   = ($urandom_range(0, 2) != 0);
         hps_we    = 1'($urandom_range(0, 1));
         hps_addr  = 26'($urandom);
         hps_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 49) == 0) gb_enable = ~gb_enable;
      if (stuck) stuck = ($urandom_range(0, 19) != 0);
      else stuck = ($urandom_range(0, 149) == 0);
      waitrequest = stuck || ($urandom_range(0, 3) == 0);
      readdata = 8'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] seq;
      int got;
      int cnt;
      bit stuck;
      gb_enable = 1; gb_req = 0; gb_we = 0; gb_addr = '0; gb_wdata = '0;
      hps_req = 0; hps_we = 0; hps_addr = '0; hps_wdata = '0;
      waitrequest = 0; readdata = '0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("rst_read", 32'(read), 32'd0);
      chk("rst_gb_rdata", 32'(gb_rdata), 32'hFF);
      chk("rst_hps_rdata", 32'(hps_rdata), 32'hFF);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      reset = 1;
      @(negedge clk);

      // Zero-wait GB read.
      gb_req = 1; gb_we = 0; gb_addr = 26'h0000100;
      waitrequest = 0; readdata = 8'h3C;
      @(negedge clk);
      chk("t1_read_c1", 32'(read), 32'd1);
      chk("t1_addr_c1", 32'(address), 32'h100);
      chk("t1_ack_c1", 32'(gb_ack), 32'd0);
      @(negedge clk);
      chk("t1_read_c2", 32'(read), 32'd0);
      chk("t1_ack_c2", 32'(gb_ack), 32'd1);
      chk("t1_rdata", 32'(gb_rdata), 32'h3C);
      gb_req = 0;
      @(negedge clk);
      chk("t1_ack_c3", 32'(gb_ack), 32'd0);

      // HPS write with three wait cycles.
      hps_req = 1; hps_we = 1; hps_addr = 26'h2000005; hps_wdata = 8'hA5;
      waitrequest = 1;
      cnt = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (write && address == 26'h2000005 && writedata == 8'hA5) cnt++;
         if (c == 4) begin
            chk("t2_ack_c4", 32'(hps_ack), 32'd0);
            waitrequest = 0;
         end
      end
      chk("t2_write_cycles", 32'(cnt), 32'd4);
      chk("t2_hps_ack_c5", 32'(hps_ack), 32'd1);
      chk("t2_gb_ack_c5", 32'(gb_ack), 32'd0);
      hps_req = 0;
      @(negedge clk);

      // Starvation bound with both ports requesting.
      gb_req = 1; gb_we = 0; gb_addr = 26'h0000040;
      hps_req = 1; hps_we = 0; hps_addr = 26'h2000040;
      collect(10, 60, 10, 1'b0, seq, got);
      chk("t3_count", 32'(got), 32'd10);
      chk("t3_seq", 32'(seq[9:0]), 32'(10'b0000100001));

      // GB disabled, then re-enabled after the fourth HPS grant.
      collect(4, 30, 4, 1'b1, seq, got);
      chk("t4_count", 32'(got), 32'd4);
      chk("t4_seq", 32'(seq[3:0]), 32'hF);
      collect(1, 10, 0, 1'b1, seq, got);
      chk("t4_gb_next", 32'({got[3:0], seq[0]}), 32'h2);
      gb_req = 0; hps_req = 0;
      repeat (2) @(negedge clk);

      // Stuck waitrequest on a GB read.
      gb_req = 1; gb_we = 0; gb_addr = 26'h0001234; waitrequest = 1;
      cnt = 0; got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
         @(negedge clk);
         if (read) cnt++;
         if (gb_ack) got = 1;
      end
      chk("t5_ack_seen", 32'(got), 32'd1);
      chk("t5_read_cycles", 32'(cnt), 32'd16);
      chk("t5_rdata", 32'(gb_rdata), 32'hFF);
      chk("t5_terr", 32'(timeout_err), 32'd1);
      gb_req = 0; waitrequest = 0;
      repeat (3) @(negedge clk);
      chk("t5_terr_sticky", 32'(timeout_err), 32'd1);

      // Reset in the middle of a stalled write.
      gb_req = 1; gb_we = 1; gb_addr = 26'h0000777; gb_wdata = 8'h11;
      waitrequest = 1;
      repeat (2) @(negedge clk);
      chk("t6_write_before", 32'(write), 32'd1);
      #2 reset = 0;
      #1;
      chk("t6_write_async", 32'(write), 32'd0);
      chk("t6_read_async", 32'(read), 32'd0);
      gb_req = 0; waitrequest = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (gb_ack || hps_ack || read || write) cnt++;
      end
      chk("t6_quiet_after", 32'(cnt), 32'd0);

      // Random traffic against the model.
      stuck = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         drive_random(stuck);
      end
      gb_req = 0; hps_req = 0; waitrequest = 0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
